// File: rtl/fetch_prefetch_queue_if.sv
// Handshake and bus bundle between the memory bus, the fetch stage and pipeline stage 1.
// The slave side is the prefetch queue; the master side drives bus, control and stall inputs.
interface fetch_prefetch_queue_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
);
    logic                       BusRequest;
    logic                       FetchSurpress;
    logic                       Flush;
    logic [DATA_W-1:0]          MEMDATA;
    logic                       PipeReady;
    logic                       Flags_5_PCRA_Flip;
    logic [DATA_W-1:0]          PipeOut;
    logic                       PipeValid;
    logic                       IncPCRA0;
    logic                       IncPCRA1;
    logic [$clog2(DEPTH+1)-1:0] Occupancy;
    logic                       QueueFull;
    logic                       QueueEmpty;

    modport master (
        output BusRequest, FetchSurpress, Flush, MEMDATA, PipeReady, Flags_5_PCRA_Flip,
        input  PipeOut, PipeValid, IncPCRA0, IncPCRA1, Occupancy, QueueFull, QueueEmpty
    );

    modport slave (
        input  BusRequest, FetchSurpress, Flush, MEMDATA, PipeReady, Flags_5_PCRA_Flip,
        output PipeOut, PipeValid, IncPCRA0, IncPCRA1, Occupancy, QueueFull, QueueEmpty
    );
endinterface

// File: rtl/fetch_prefetch_queue.sv
// Instruction-fetch stage 0: DEPTH-entry prefetch FIFO between the memory data bus and stage 1,
// with branch flush, PC increment selection and NOP substitution when no word is available.
module fetch_prefetch_queue #(
    parameter int                DATA_W    = 8,
    parameter int                DEPTH     = 4,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0
) (
    input logic                   ClockIn,
    input logic                   ResetIn_n,
    fetch_prefetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] entries [DEPTH];
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [OCC_W-1:0]  occupancy;
    logic              queueFull;
    logic              queueEmpty;
    logic              pop;
    logic              fetch;

    // Full/empty come from the occupancy count; the pointers alone cannot tell them apart.
    assign queueEmpty = (occupancy == '0);
    assign queueFull  = (occupancy == OCC_W'(DEPTH));
    assign pop        = ~queueEmpty & bus.PipeReady;
    assign fetch      = ResetIn_n & ~bus.Flush & ~bus.BusRequest & ~bus.FetchSurpress
                      & (~queueFull | pop);

    // NOTE: queue storage has no reset; occupancy alone decides which entries are meaningful,
    // so clearing the array would only cost reset fan-out.
    always_ff @(posedge ClockIn) begin
        if (fetch) begin
            entries[wrPtr] <= bus.MEMDATA;
        end
    end

    // NOTE: all state updates use non-blocking assignment so every register samples
    // pre-edge values and the pointer/occupancy updates stay mutually consistent.
    always_ff @(posedge ClockIn) begin
        if (!ResetIn_n || bus.Flush) begin
            rdPtr     <= '0;
            wrPtr     <= '0;
            occupancy <= '0;
        end else begin
            if (fetch) begin
                wrPtr <= wrPtr + PTR_W'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PTR_W'(1);
            end
            if (fetch && !pop) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (pop && !fetch) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

    assign bus.PipeOut    = queueEmpty ? NOP_VALUE : entries[rdPtr];
    assign bus.PipeValid  = ~queueEmpty;
    assign bus.IncPCRA0   = fetch & ~bus.Flags_5_PCRA_Flip;
    assign bus.IncPCRA1   = fetch & bus.Flags_5_PCRA_Flip;
    assign bus.Occupancy  = occupancy;
    assign bus.QueueFull  = queueFull;
    assign bus.QueueEmpty = queueEmpty;
endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue (DATA_W=8, DEPTH=4): one table row per clock cycle,
// outputs checked before the rising edge that consumes the row's inputs.
module tb_fetch_prefetch_queue;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 4;

    typedef struct {
        logic       rstN;
        logic       busReq;
        logic       supp;
        logic       flush;
        logic [7:0] mem;
        logic       ready;
        logic       flip;
        logic [7:0] expOut;
        logic       expValid;
        logic       expInc0;
        logic       expInc1;
        int         expOcc;
    } vec_t;

    logic ClockIn;
    logic ResetIn_n;
    int   checks;
    int   errors;
    vec_t vecs[$];

    fetch_prefetch_queue_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) pq ();

    fetch_prefetch_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH), .NOP_VALUE(8'h00)) dut (
        .ClockIn   (ClockIn),
        .ResetIn_n (ResetIn_n),
        .bus       (pq)
    );

    initial ClockIn = 1'b0;
    always #5 ClockIn = ~ClockIn;

    function automatic vec_t mkVec(logic rstN, logic busReq, logic supp, logic flush,
                                   logic [7:0] mem, logic ready, logic flip,
                                   logic [7:0] expOut, logic expValid, logic expInc0,
                                   logic expInc1, int expOcc);
        vec_t v;
        v.rstN = rstN;     v.busReq = busReq;     v.supp = supp;       v.flush = flush;
        v.mem = mem;       v.ready = ready;       v.flip = flip;       v.expOut = expOut;
        v.expValid = expValid; v.expInc0 = expInc0; v.expInc1 = expInc1; v.expOcc = expOcc;
        return v;
    endfunction

    task automatic check(input string name, input int row, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s row %0d: got %0h expected %0h", name, row, actual, expected);
        end
    endtask

    task automatic drive(input vec_t v);
        ResetIn_n            = v.rstN;
        pq.BusRequest        = v.busReq;
        pq.FetchSurpress     = v.supp;
        pq.Flush             = v.flush;
        pq.MEMDATA           = v.mem;
        pq.PipeReady         = v.ready;
        pq.Flags_5_PCRA_Flip = v.flip;
    endtask

    task automatic checkAll(input vec_t v, input int row);
        check("PipeOut",    row, int'(pq.PipeOut),    int'(v.expOut));
        check("PipeValid",  row, int'(pq.PipeValid),  int'(v.expValid));
        check("IncPCRA0",   row, int'(pq.IncPCRA0),   int'(v.expInc0));
        check("IncPCRA1",   row, int'(pq.IncPCRA1),   int'(v.expInc1));
        check("Occupancy",  row, int'(pq.Occupancy),  v.expOcc);
        check("QueueFull",  row, int'(pq.QueueFull),  (v.expOcc == DEPTH) ? 1 : 0);
        check("QueueEmpty", row, int'(pq.QueueEmpty), (v.expOcc == 0) ? 1 : 0);
    endtask

    // Drive at the falling edge, check 1 time unit later, the rising edge then consumes the row.
    task automatic runVec(input vec_t v, input int row);
        @(negedge ClockIn);
        drive(v);
        #1;
        checkAll(v, row);
    endtask

    initial begin
        checks = 0;
        errors = 0;

        //           rst bus sup fl  mem    rdy flp  out    v  i0 i1 occ
        // Reset with a fetchable word on the bus, then release.
        vecs.push_back(mkVec(0, 0, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 0, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'hAA, 0, 0, 8'h00, 0, 1, 0, 0));
        // Streaming with PipeReady=1: occupancy stays at 1.
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h10, 1, 0, 8'hAA, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h11, 1, 0, 8'h10, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h12, 1, 0, 8'h11, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'hEE, 1, 0, 8'h12, 1, 0, 0, 1));
        // Stall and fill to full, then pop on full (fetch still taken).
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h20, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h21, 0, 0, 8'h20, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h22, 0, 0, 8'h20, 1, 1, 0, 2));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h23, 0, 0, 8'h20, 1, 1, 0, 3));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h24, 0, 0, 8'h20, 1, 0, 0, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h24, 1, 0, 8'h20, 1, 1, 0, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h25, 1, 0, 8'h21, 1, 1, 0, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h26, 1, 0, 8'h22, 1, 1, 0, 4));
        // Bus steal x2, suppress x1, both x1: queue drains, no increments.
        vecs.push_back(mkVec(1, 1, 0, 0, 8'h77, 1, 0, 8'h23, 1, 0, 0, 4));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'h78, 1, 0, 8'h24, 1, 0, 0, 3));
        vecs.push_back(mkVec(1, 0, 1, 0, 8'h79, 1, 0, 8'h25, 1, 0, 0, 2));
        vecs.push_back(mkVec(1, 1, 1, 0, 8'h7A, 1, 0, 8'h26, 1, 0, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h30, 1, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h31, 1, 0, 8'h30, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h32, 0, 0, 8'h31, 1, 1, 0, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h33, 0, 0, 8'h31, 1, 1, 0, 2));
        // Flush at occupancy 3; 0x66 is the next word presented.
        vecs.push_back(mkVec(1, 0, 0, 1, 8'h55, 1, 0, 8'h31, 1, 0, 0, 3));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h66, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h67, 1, 0, 8'h66, 1, 1, 0, 1));
        // PCRA1 selected, PipeReady toggling, pointers wrap.
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h80, 0, 1, 8'h67, 1, 0, 1, 1));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h81, 1, 1, 8'h67, 1, 0, 1, 2));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h82, 0, 1, 8'h80, 1, 0, 1, 2));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h83, 1, 1, 8'h80, 1, 0, 1, 3));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h84, 0, 1, 8'h81, 1, 0, 1, 3));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h85, 1, 1, 8'h81, 1, 0, 1, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h86, 0, 1, 8'h82, 1, 0, 0, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h86, 1, 1, 8'h82, 1, 0, 1, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h87, 1, 1, 8'h83, 1, 0, 1, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h88, 0, 1, 8'h84, 1, 0, 0, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h88, 1, 1, 8'h84, 1, 0, 1, 4));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h89, 1, 1, 8'h85, 1, 0, 1, 4));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'hEE, 1, 1, 8'h86, 1, 0, 0, 4));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'hEE, 1, 1, 8'h87, 1, 0, 0, 3));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'hEE, 1, 1, 8'h88, 1, 0, 0, 2));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'hEE, 1, 1, 8'h89, 1, 0, 0, 1));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'hEE, 1, 1, 8'h00, 0, 0, 0, 0));
        // Reset mid-operation: fetch in the reset cycle is ignored.
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h90, 0, 0, 8'h00, 0, 1, 0, 0));
        vecs.push_back(mkVec(1, 0, 0, 0, 8'h91, 0, 0, 8'h90, 1, 1, 0, 1));
        vecs.push_back(mkVec(0, 0, 0, 0, 8'h92, 1, 0, 8'h90, 1, 0, 0, 2));
        vecs.push_back(mkVec(1, 1, 0, 0, 8'h93, 1, 0, 8'h00, 0, 0, 0, 0));

        // First reset edge establishes a known state before any check.
        drive(vecs[0]);
        @(posedge ClockIn);

        for (int i = 0; i < vecs.size(); i++) begin
            runVec(vecs[i], i);
        end

        // Flush of a full queue with PipeReady=1: head word discarded, no PC increment.
        begin
            vec_t v;
            for (int i = 0; i < DEPTH; i++) begin
                v = mkVec(1, 0, 0, 0, 8'hA0 + 8'(i), 0, 0,
                          (i == 0) ? 8'h00 : 8'hA0, (i != 0), 1, 0, i);
                runVec(v, 100 + i);
            end
            v = mkVec(1, 0, 0, 1, 8'h55, 1, 0, 8'hA0, 1, 0, 0, DEPTH);
            runVec(v, 110);
            v = mkVec(1, 1, 0, 0, 8'h56, 1, 0, 8'h00, 0, 0, 0, 0);
            runVec(v, 111);
        end

        @(negedge ClockIn);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
